aes_gcm_output_collector: RTL and testbench

Consumer end of the per-block counter/phase stream that the pipeline front stage generates for the parallel AES workers. It accepts finished blocks from N_WORKERS encryption workers in any order, each tagged with its block counter and phase code. It reorders them into strict counter order, drops AAD and invalid blocks, and emits a single in-order ciphertext stream with valid/ready handshake and an end-of-instance marker. It sits after the worker array and before the GHASH/tag and frame-output logic.

---
 rtl/aes_gcm_output_collector.sv | 171 +++++++++++++++++
 tb/tb_aes_gcm_output_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_gcm_output_collector.sv
// Reorders out-of-order AES worker results into a single in-order ciphertext stream.
// AAD and invalid blocks are filtered out; an end-of-instance marker accompanies the final text block.
module aes_gcm_output_collector #(
  parameter int N_WORKERS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_new_instance,
  input  logic [127:0]             i_first_counter,
  input  logic [N_WORKERS-1:0]     i_valid,
  input  logic [N_WORKERS*128-1:0] i_counter,
  input  logic [N_WORKERS*3-1:0]   i_phase,
  input  logic [N_WORKERS*128-1:0] i_cipher_text,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [127:0]             o_data,
  output logic [127:0]             o_counter,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic                     o_seq_err
);

  localparam int IDXW = $clog2(N_WORKERS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q;
  logic [127:0]         exp_q;
  logic [N_WORKERS-1:0] slotValid_q;
  logic [127:0]         slotData_q  [N_WORKERS];
  logic [127:0]         slotCnt_q   [N_WORKERS];
  logic [2:0]           slotPhase_q [N_WORKERS];

  logic                 oValid_q;
  logic [127:0]         oData_q;
  logic [127:0]         oCnt_q;
  logic                 oLast_q;
  logic                 ovf_q;
  logic                 seqErr_q;

  logic [IDXW-1:0]      headIdx;
  logic                 headHit;
  logic                 headLast;
  logic                 xferLast;
  logic                 loadHead;
  logic                 acceptOn;
  logic [N_WORKERS-1:0] wrEn;
  logic [IDXW-1:0]      wrSlot [N_WORKERS];
  logic [N_WORKERS-1:0] claimed;
  logic                 ovfHit;
  logic                 seqHit;

  // Head selection and output register load decision.
  always_comb begin
    headIdx  = exp_q[IDXW-1:0];
    headHit  = slotValid_q[headIdx] && (slotCnt_q[headIdx] == exp_q);
    headLast = (slotPhase_q[headIdx] == 3'b011) || (slotPhase_q[headIdx] == 3'b111);
    xferLast = oValid_q && i_ready && oLast_q;
    acceptOn = (state_q == RUN) && !i_new_instance;
    loadHead = acceptOn && headHit && (!oValid_q || i_ready) && !xferLast;
  end

  // Per-worker acceptance; lower worker index claims a contested slot first.
  always_comb begin
    wrEn    = '0;
    claimed = '0;
    ovfHit  = 1'b0;
    seqHit  = 1'b0;
    for (int k = 0; k < N_WORKERS; k++) begin
      wrSlot[k] = i_counter[k*128 +: IDXW];
      if (acceptOn && i_valid[k] &&
          (i_phase[k*3 +: 3] != 3'b010) && (i_phase[k*3 +: 3] != 3'b100)) begin
        if (i_counter[k*128 +: 128] < exp_q) begin
          seqHit = 1'b1;
        end else if (claimed[wrSlot[k]] ||
                     (slotValid_q[wrSlot[k]] && !(loadHead && (wrSlot[k] == headIdx)))) begin
          ovfHit = 1'b1;
        end else begin
          claimed[wrSlot[k]] = 1'b1;
          wrEn[k]            = 1'b1;
        end
      end
    end
  end

  // Control FSM, slot occupancy, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      slotValid_q <= '0;
      oValid_q    <= 1'b0;
      oData_q     <= '0;
      oCnt_q      <= '0;
      oLast_q     <= 1'b0;
      ovf_q       <= 1'b0;
      seqErr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_new_instance) begin
            state_q     <= RUN;
            exp_q       <= i_first_counter;
            slotValid_q <= '0;
            ovf_q       <= 1'b0;
            seqErr_q    <= 1'b0;
          end
        end
        RUN: begin
          if (i_new_instance) begin
            exp_q       <= i_first_counter;
            slotValid_q <= '0;
            oValid_q    <= 1'b0;
            oData_q     <= '0;
            oCnt_q      <= '0;
            oLast_q     <= 1'b0;
            ovf_q       <= 1'b0;
            seqErr_q    <= 1'b0;
          end else begin
            if (ovfHit) ovf_q <= 1'b1;
            if (seqHit) seqErr_q <= 1'b1;
            if (xferLast) begin
              state_q     <= IDLE;
              slotValid_q <= '0;
              oValid_q    <= 1'b0;
            end else begin
              if (loadHead) begin
                oValid_q             <= 1'b1;
                oData_q              <= slotData_q[headIdx];
                oCnt_q               <= slotCnt_q[headIdx];
                oLast_q              <= headLast;
                slotValid_q[headIdx] <= 1'b0;
                exp_q                <= exp_q + 128'd1;
              end else if (i_ready) begin
                oValid_q <= 1'b0;
              end
              // Later assignment lets a slot freed by this load be refilled in the same cycle.
              for (int k = 0; k < N_WORKERS; k++) begin
                if (wrEn[k]) slotValid_q[wrSlot[k]] <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_WORKERS; k++) begin
      if (wrEn[k]) begin
        slotData_q[wrSlot[k]]  <= i_cipher_text[k*128 +: 128];
        slotCnt_q[wrSlot[k]]   <= i_counter[k*128 +: 128];
        slotPhase_q[wrSlot[k]] <= i_phase[k*3 +: 3];
      end
    end
  end

  assign o_valid    = oValid_q;
  assign o_data     = oData_q;
  assign o_counter  = oCnt_q;
  assign o_last     = oLast_q;
  assign o_busy     = (state_q == RUN);
  assign o_overflow = ovf_q;
  assign o_seq_err  = seqErr_q;

endmodule

// File: tb/tb_aes_gcm_output_collector.sv
// Scoreboard bench for aes_gcm_output_collector: expected blocks are queued as stimulus
// is driven and compared against every accepted output transfer.
module tb_aes_gcm_output_collector;

  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_new_instance;
  logic [127:0]    i_first_counter;
  logic [NW-1:0]   i_valid;
  logic [NW*128-1:0] i_counter;
  logic [NW*3-1:0] i_phase;
  logic [NW*128-1:0] i_cipher_text;
  logic            i_ready;
  logic            o_valid;
  logic [127:0]    o_data;
  logic [127:0]    o_counter;
  logic            o_last;
  logic            o_busy;
  logic            o_overflow;
  logic            o_seq_err;

  typedef struct packed {
    logic [127:0] cnt;
    logic         last;
  } expT;

  expT sbQ[$];
  int  checkCount = 0;
  int  errorCount = 0;

  aes_gcm_output_collector #(.N_WORKERS(NW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_new_instance  (i_new_instance),
    .i_first_counter (i_first_counter),
    .i_valid         (i_valid),
    .i_counter       (i_counter),
    .i_phase         (i_phase),
    .i_cipher_text   (i_cipher_text),
    .i_ready         (i_ready),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_counter       (o_counter),
    .o_last          (o_last),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow),
    .o_seq_err       (o_seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dataOf(input logic [127:0] c);
    return {c[63:0] ^ 64'hA5A5_5A5A_0F0F_F0F0, ~c[63:0]} + 128'h1357;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [127:0] c, input logic last);
    expT e;
    e.cnt  = c;
    e.last = last;
    sbQ.push_back(e);
  endtask

  task automatic setWorker(input int k, input logic [127:0] c, input logic [2:0] ph);
    i_valid[k]                = 1'b1;
    i_counter[k*128 +: 128]   = c;
    i_phase[k*3 +: 3]         = ph;
    i_cipher_text[k*128 +: 128] = dataOf(c);
  endtask

  // One clock with the currently driven inputs, then drop the one-cycle pulses.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    i_valid        = '0;
    i_new_instance = 1'b0;
  endtask

  task automatic newInstance(input logic [127:0] fc);
    i_new_instance  = 1'b1;
    i_first_counter = fc;
    applyStimulus();
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drainTimeout", 128'(sbQ.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOut", 128'(sbQ.size()), 128'd1);
      end else begin
        expT e;
        e = sbQ.pop_front();
        checkOutput("outCnt", o_counter, e.cnt);
        checkOutput("outData", o_data, dataOf(e.cnt));
        checkOutput("outLast", 128'(o_last), 128'(e.last));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; i_new_instance = 1'b0; i_first_counter = '0; i_valid = '0;
    i_counter = '0; i_phase = '0; i_cipher_text = '0; i_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("rstValid", 128'(o_valid), 128'd0);
    checkOutput("rstData", o_data, 128'd0);
    checkOutput("rstBusy", 128'(o_busy), 128'd0);
    checkOutput("rstOvf", 128'(o_overflow), 128'd0);
    checkOutput("rstSeq", 128'(o_seq_err), 128'd0);

    $display("[TB] in-order stream");
    i_ready = 1'b1;
    newInstance(128'd2);
    checkOutput("newBusy", 128'(o_busy), 128'd1);
    checkOutput("newValid", 128'(o_valid), 128'd0);
    pushExp(128'd2, 1'b0); pushExp(128'd3, 1'b0); pushExp(128'd4, 1'b1);
    setWorker(0, 128'd2, 3'b000); applyStimulus();
    checkOutput("latencyEarly", 128'(o_valid), 128'd0);
    setWorker(1, 128'd3, 3'b001); applyStimulus();
    checkOutput("latencyValid", 128'(o_valid), 128'd1);
    checkOutput("latencyCnt", o_counter, 128'd2);
    setWorker(2, 128'd4, 3'b011); applyStimulus();
    waitDrain(20);
    applyStimulus();
    checkOutput("inOrderBusyEnd", 128'(o_busy), 128'd0);
    checkOutput("inOrderValidEnd", 128'(o_valid), 128'd0);

    $display("[TB] out-of-order stream");
    newInstance(128'd3);
    pushExp(128'd3, 1'b0); pushExp(128'd4, 1'b0); pushExp(128'd5, 1'b1);
    setWorker(0, 128'd5, 3'b011); applyStimulus();
    setWorker(1, 128'd4, 3'b001); applyStimulus();
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("oooNoEarly", 128'(o_valid), 128'd0);
    setWorker(2, 128'd3, 3'b000); applyStimulus();
    waitDrain(20);
    applyStimulus();
    checkOutput("oooBusyEnd", 128'(o_busy), 128'd0);

    $display("[TB] backpressure with same-cycle slot reuse");
    i_ready = 1'b0;
    newInstance(128'd8);
    for (int i = 8; i < 14; i++) pushExp(128'(i), (i == 13));
    for (int k = 0; k < NW; k++) setWorker(k, 128'(8 + k), (k == 0) ? 3'b000 : 3'b001);
    applyStimulus();
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpValid", 128'(o_valid), 128'd1);
      checkOutput("bpHold", o_data, dataOf(128'd8));
      applyStimulus();
    end
    i_ready = 1'b1;
    setWorker(0, 128'd12, 3'b001);
    setWorker(1, 128'd13, 3'b011);
    for (int i = 0; i < 6; i++) begin
      checkOutput("b2bCnt", o_counter, 128'(8 + i));
      applyStimulus();
    end
    checkOutput("b2bValidEnd", 128'(o_valid), 128'd0);
    checkOutput("b2bBusyEnd", 128'(o_busy), 128'd0);
    checkOutput("b2bNoOvf", 128'(o_overflow), 128'd0);

    $display("[TB] single first-and-last block");
    newInstance(128'd0);
    pushExp(128'd0, 1'b1);
    setWorker(3, 128'd0, 3'b111); applyStimulus();
    waitDrain(20);
    applyStimulus();
    checkOutput("singleBusyEnd", 128'(o_busy), 128'd0);

    $display("[TB] filtering and error flags");
    newInstance(128'd0);
    setWorker(0, 128'd0, 3'b010);
    setWorker(1, 128'd0, 3'b100);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("aadNoOut", 128'(o_valid), 128'd0);
    checkOutput("aadNoOvf", 128'(o_overflow), 128'd0);
    checkOutput("aadNoSeq", 128'(o_seq_err), 128'd0);
    newInstance(128'd3);
    setWorker(1, 128'd1, 3'b001); applyStimulus();
    checkOutput("staleSeqErr", 128'(o_seq_err), 128'd1);
    checkOutput("staleNoOut", 128'(o_valid), 128'd0);
    pushExp(128'd3, 1'b1);
    setWorker(0, 128'd3, 3'b111);
    setWorker(2, 128'd7, 3'b001);
    applyStimulus();
    checkOutput("collideOvf", 128'(o_overflow), 128'd1);
    checkOutput("seqSticky", 128'(o_seq_err), 128'd1);
    waitDrain(20);
    applyStimulus();
    checkOutput("ovfStickyIdle", 128'(o_overflow), 128'd1);

    $display("[TB] occupied slot then abort");
    i_ready = 1'b0;
    newInstance(128'd3);
    checkOutput("clrOvf", 128'(o_overflow), 128'd0);
    checkOutput("clrSeq", 128'(o_seq_err), 128'd0);
    setWorker(1, 128'd4, 3'b001); applyStimulus();
    setWorker(3, 128'd8, 3'b001); applyStimulus();
    checkOutput("occupiedOvf", 128'(o_overflow), 128'd1);
    setWorker(2, 128'd5, 3'b001); applyStimulus();
    applyStimulus();
    checkOutput("abortPreValid", 128'(o_valid), 128'd0);
    i_ready = 1'b1;
    newInstance(128'd20);
    checkOutput("abortValid", 128'(o_valid), 128'd0);
    checkOutput("abortBusy", 128'(o_busy), 128'd1);
    checkOutput("abortOvfClr", 128'(o_overflow), 128'd0);
    pushExp(128'd20, 1'b1);
    setWorker(0, 128'd20, 3'b111); applyStimulus();
    waitDrain(20);
    applyStimulus();
    checkOutput("abortBusyEnd", 128'(o_busy), 128'd0);

    $display("[TB] reset mid-stream");
    i_ready = 1'b0;
    newInstance(128'd0);
    setWorker(0, 128'd0, 3'b000);
    setWorker(1, 128'd1, 3'b001);
    applyStimulus();
    applyStimulus();
    checkOutput("preRstValid", 128'(o_valid), 128'd1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("midRstValid", 128'(o_valid), 128'd0);
    checkOutput("midRstData", o_data, 128'd0);
    checkOutput("midRstCnt", o_counter, 128'd0);
    checkOutput("midRstBusy", 128'(o_busy), 128'd0);
    applyStimulus();

    checkOutput("sbLeftover", 128'(sbQ.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
